// File: rtl/full_adder_pkg.sv
// Shared types and a reference model for the registered ripple-carry adder.
// fa_ref is a plain arithmetic model that is independent of the bit-cell chain.
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;

    typedef logic [FA_DEFAULT_WIDTH-1:0] fa_word_t;

    typedef struct packed {
        logic     c_out;
        fa_word_t s;
    } fa_result_t;

    function automatic fa_result_t fa_ref(fa_word_t a, fa_word_t b, logic c_in);
        logic [FA_DEFAULT_WIDTH:0] total;
        total = {1'b0, a} + {1'b0, b} + {{FA_DEFAULT_WIDTH{1'b0}}, c_in};
        return fa_result_t'(total);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full-adder cell; chained bit by bit to form the ripple adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ c_in;
    assign c_out    = (a & b) | (c_in & half_sum);

endmodule

// File: rtl/full_adder.sv
// Parameterisable ripple-carry adder with a registered sum and carry-out.
// The result of inputs sampled at one rising edge appears just after that edge.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("full_adder: WIDTH must be in 1..64");
        end
    endgenerate

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;

    assign carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            full_adder_cell u_cell (
                .a     (a[gi]),
                .b     (b[gi]),
                .c_in  (carry[gi]),
                .s     (sum_next[gi]),
                .c_out (carry[gi+1])
            );
        end
    endgenerate

    // Reset clears the outputs at once and discards any result in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s     <= '0;
            c_out <= 1'b0;
        end else begin
            s     <= sum_next;
            c_out <= carry[WIDTH];
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random bench for full_adder at WIDTH 1, 8 and 16 with a scoreboard per instance.
module tb_full_adder;
    import full_adder_pkg::*;

    logic clk;
    logic rst;

    logic        a1, b1, ci1, s1, co1;
    logic [7:0]  a8, b8, s8;
    logic        ci8, co8;
    logic [15:0] a16, b16, s16;
    logic        ci16, co16;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(ci1), .s(s1), .c_out(co1)
    );
    full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(ci8), .s(s8), .c_out(co8)
    );
    full_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .c_in(ci16), .s(s16), .c_out(co16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected {c_out, s} values, zero-extended, one queue per instance.
    logic [64:0] q1[$];
    logic [64:0] q8[$];
    logic [64:0] q16[$];

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [64:0] obs_of(input int w);
        logic [64:0] v;
        v = '0;
        case (w)
            1:       v = {63'b0, co1, s1};
            8:       v = {56'b0, co8, s8};
            default: v = {48'b0, co16, s16};
        endcase
        return v;
    endfunction

    task automatic pop_check(input int w, input string tag);
        logic [64:0] exp;
        logic        empty;
        empty = 1'b0;
        exp   = '0;
        case (w)
            1:       if (q1.size()  == 0) empty = 1'b1; else exp = q1.pop_front();
            8:       if (q8.size()  == 0) empty = 1'b1; else exp = q8.pop_front();
            default: if (q16.size() == 0) empty = 1'b1; else exp = q16.pop_front();
        endcase
        if (empty) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty observed=%h", tag, obs_of(w));
        end else begin
            check(tag, obs_of(w), exp);
        end
    endtask

    // Exhaustive 1-bit truth table, index {a,b,c_in} -> {c_out,s}.
    logic [1:0] truth [8];
    fa_result_t ref_r;
    logic [16:0] e16;

    initial begin
        truth[0] = 2'b00; truth[1] = 2'b01; truth[2] = 2'b01; truth[3] = 2'b10;
        truth[4] = 2'b01; truth[5] = 2'b10; truth[6] = 2'b10; truth[7] = 2'b11;

        // Reset asserted with all-ones inputs.
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1;
        #1;
        check("reset_w1_now", obs_of(1), 65'd0);
        check("reset_w8_now", obs_of(8), 65'd0);
        check("reset_w16_now", obs_of(16), 65'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("reset_w1_edge", obs_of(1), 65'd0);
            check("reset_w8_edge", obs_of(8), 65'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive WIDTH=1, back to back.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            {a1, b1, ci1} = v;
            q1.push_back({63'b0, truth[i]});
            @(posedge clk); #1;
            pop_check(1, $sformatf("w1_abc_%0d", i));
            @(negedge clk);
        end

        // WIDTH=8 boundary vectors with hand-computed results.
        a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1; q8.push_back(65'h100);
        @(posedge clk); #1; pop_check(8, "w8_ripple");
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; q8.push_back(65'h1FF);
        @(posedge clk); #1; pop_check(8, "w8_max");
        @(negedge clk);
        a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0; q8.push_back(65'h000);
        @(posedge clk); #1; pop_check(8, "w8_zero");
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h25; ci8 = 1'b0; q8.push_back(65'h07F);
        @(posedge clk); #1; pop_check(8, "w8_nocarry");
        @(negedge clk);

        // Asynchronous reset in the middle of a stream.
        a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0; q1.push_back(65'd1);
        @(posedge clk); #1; pop_check(1, "w1_pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check("w1_async_clear", obs_of(1), 65'd0);
        q1.delete();
        @(posedge clk); #1;
        check("w1_rst_hold", obs_of(1), 65'd0);
        @(negedge clk);
        rst = 1'b0;
        ref_r = fa_ref(fa_word_t'(a1), fa_word_t'(b1), ci1);
        q1.push_back({63'b0, ref_r.c_out, ref_r.s});
        @(posedge clk); #1; pop_check(1, "w1_post_rst");
        @(negedge clk);

        // Random regression, WIDTH=16.
        for (int i = 0; i < 1000; i++) begin
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            ci16 = 1'($urandom_range(0, 1));
            e16  = {1'b0, a16} + {1'b0, b16} + {16'b0, ci16};
            q16.push_back({48'b0, e16});
            @(posedge clk); #1;
            pop_check(16, "w16_rand");
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
